// File: rtl/juggle_pkg.sv
// Shared types and sizing for the siteswap scheduler.
package juggle_pkg;

  localparam int MAX_LEN    = 7;
  localparam int MAX_HEIGHT = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ERROR = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic       occ;
    logic [2:0] id;
  } slot_t;

endpackage

// File: rtl/landing_schedule.sv
// Landing-slot shift register: slot[i] holds the ball landing i beats from now.
// SCHED_OCCUPANCY_EN exposes the occupancy vector.
module landing_schedule
  import juggle_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        clear,
  input  logic        shift,
  input  logic        place,
  input  logic [2:0]  place_idx,
  input  logic [2:0]  place_id,
  input  logic [2:0]  probe_idx,
  output slot_t       head,
  output logic        collide
`ifdef SCHED_OCCUPANCY_EN
  ,
  output logic [MAX_HEIGHT-1:0] occupancy
`endif
);

  slot_t slots [MAX_HEIGHT];

  // place is applied after clear/shift so a throw lands in the post-shift schedule
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < MAX_HEIGHT; i++) slots[i] <= '0;
    end else begin
      if (clear) begin
        for (int i = 0; i < MAX_HEIGHT; i++) slots[i] <= '0;
      end else if (shift) begin
        for (int i = 0; i < MAX_HEIGHT - 1; i++) slots[i] <= slots[i+1];
        slots[MAX_HEIGHT-1] <= '0;
      end
      if (place) slots[place_idx] <= '{occ: 1'b1, id: place_id};
    end
  end

  assign head = slots[0];

  // probe_idx is a post-shift index, so it looks one slot higher pre-shift
  always_comb begin
    collide = 1'b0;
    if (probe_idx < 3'(MAX_HEIGHT - 1)) collide = slots[probe_idx + 3'd1].occ;
  end

`ifdef SCHED_OCCUPANCY_EN
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < MAX_HEIGHT; i++) occupancy[i] = slots[i].occ;
  end
`endif

endmodule

// File: rtl/siteswap_scheduler.sv
// Beat-by-beat siteswap scheduler: FSM, pattern index, hand and ball counter.
// SCHED_OCCUPANCY_EN adds occupancy_out.
//   state | meaning
//   IDLE  | no pattern running, schedule empty
//   RUN   | processing one beat per new_beat strobe
//   ERROR | collision / dropped ball / starvation, schedule frozen
module siteswap_scheduler
  import juggle_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        new_beat,
  input  logic [2:0]  pattern_in [MAX_LEN],
  input  logic [2:0]  pattern_length,
  input  logic [2:0]  num_balls_in,
  input  logic        pattern_valid_in,
  output logic        throw_valid_out,
  output logic [2:0]  throw_height_out,
  output logic [2:0]  throw_ball_out,
  output logic        throw_hand_out,
  output logic [2:0]  beat_index_out,
  output logic [2:0]  balls_live_out,
  output logic        error_out,
  output logic        running_out
`ifdef SCHED_OCCUPANCY_EN
  ,
  output logic [MAX_HEIGHT-1:0] occupancy_out
`endif
);

  sched_state_t state_q, state_d;
  logic [2:0] pat_q [MAX_LEN];
  logic [2:0] len_q, nb_q, idx_q, live_q;
  logic       hand_q;

  logic       latch, proc, fresh, changed, err, advance, throw_fire;
  logic       sched_clear, sched_shift, sched_place, collide;
  logic [2:0] h_cur, nb_cur, len_cur, idx_cur, live_cur, live_d, throw_id, tgt_idx;
  logic       hand_cur;
  slot_t      head, head_cur;

  landing_schedule u_sched (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .clear     (sched_clear),
    .shift     (sched_shift),
    .place     (sched_place),
    .place_idx (tgt_idx),
    .place_id  (throw_id),
    .probe_idx (tgt_idx),
    .head      (head),
    .collide   (collide)
`ifdef SCHED_OCCUPANCY_EN
    ,
    .occupancy (occupancy_out)
`endif
  );

  always_comb begin
    changed = (pattern_length != len_q) || (num_balls_in != nb_q);
    for (int i = 0; i < MAX_LEN; i++)
      if (pattern_in[i] != pat_q[i]) changed = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    latch       = 1'b0;
    proc        = 1'b0;
    sched_clear = 1'b0;
    sched_shift = 1'b0;
    sched_place = 1'b0;
    throw_fire  = 1'b0;
    advance     = 1'b0;
    err         = 1'b0;
    unique case (state_q)
      IDLE: if (new_beat && pattern_valid_in) begin
        latch = 1'b1;
        proc  = 1'b1;
      end
      RUN: if (new_beat) begin
        if (!pattern_valid_in) begin
          state_d     = IDLE;
          sched_clear = 1'b1;
        end else begin
          latch = changed;
          proc  = 1'b1;
        end
      end
      ERROR: if (new_beat && !pattern_valid_in) begin
        state_d     = IDLE;
        sched_clear = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A freshly latched pattern runs as beat 0 against an empty schedule
    fresh    = latch;
    h_cur    = fresh ? pattern_in[0]  : pat_q[idx_q];
    nb_cur   = fresh ? num_balls_in   : nb_q;
    len_cur  = fresh ? pattern_length : len_q;
    idx_cur  = fresh ? 3'd0 : idx_q;
    live_cur = fresh ? 3'd0 : live_q;
    hand_cur = fresh ? 1'b0 : hand_q;
    head_cur = fresh ? slot_t'('0) : head;
    tgt_idx  = h_cur - 3'd1;
    live_d   = live_cur;
    throw_id = head_cur.id;

    if (proc) begin
      if (h_cur == 3'd0) begin
        err = head_cur.occ;
      end else begin
        if (head_cur.occ) begin
          throw_fire = 1'b1;
        end else if (live_cur < nb_cur) begin
          throw_fire = 1'b1;
          throw_id   = live_cur;
          live_d     = live_cur + 3'd1;
        end else begin
          err = 1'b1;
        end
        if (collide && !fresh) err = 1'b1;
      end
      sched_clear = fresh;
      if (err) begin
        throw_fire = 1'b0;
        state_d    = ERROR;
      end else begin
        state_d     = RUN;
        advance     = 1'b1;
        sched_shift = !fresh;
        sched_place = throw_fire;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < MAX_LEN; i++) pat_q[i] <= '0;
      len_q            <= '0;
      nb_q             <= '0;
      idx_q            <= '0;
      live_q           <= '0;
      hand_q           <= 1'b0;
      throw_valid_out  <= 1'b0;
      throw_height_out <= '0;
      throw_ball_out   <= '0;
      throw_hand_out   <= 1'b0;
      beat_index_out   <= '0;
    end else begin
      throw_valid_out <= throw_fire;
      if (latch) begin
        pat_q <= pattern_in;
        len_q <= pattern_length;
        nb_q  <= num_balls_in;
      end
      if (sched_clear) live_q <= '0;
      if (advance) begin
        live_q         <= live_d;
        hand_q         <= ~hand_cur;
        idx_q          <= (idx_cur >= len_cur - 3'd1) ? 3'd0 : idx_cur + 3'd1;
        beat_index_out <= idx_cur;
        throw_hand_out <= hand_cur;
      end
      if (throw_fire) begin
        throw_height_out <= h_cur;
        throw_ball_out   <= throw_id;
      end
    end
  end

  assign balls_live_out = live_q;
  assign error_out      = (state_q == ERROR);
  assign running_out    = (state_q == RUN);

endmodule

// File: tb/tb_siteswap_scheduler.sv
// Directed self-checking bench for siteswap_scheduler (SCHED_OCCUPANCY_EN adds occupancy checks).
module tb_siteswap_scheduler;
  import juggle_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       new_beat = 1'b0;
  logic [2:0] pattern_in [MAX_LEN];
  logic [2:0] pattern_length = 3'd0;
  logic [2:0] num_balls_in = 3'd0;
  logic       pattern_valid_in = 1'b0;
  logic       throw_valid_out, throw_hand_out, error_out, running_out;
  logic [2:0] throw_height_out, throw_ball_out, beat_index_out, balls_live_out;
`ifdef SCHED_OCCUPANCY_EN
  logic [MAX_HEIGHT-1:0] occupancy_out;
`endif

  int checks = 0;
  int errors = 0;

  siteswap_scheduler dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .new_beat         (new_beat),
    .pattern_in       (pattern_in),
    .pattern_length   (pattern_length),
    .num_balls_in     (num_balls_in),
    .pattern_valid_in (pattern_valid_in),
    .throw_valid_out  (throw_valid_out),
    .throw_height_out (throw_height_out),
    .throw_ball_out   (throw_ball_out),
    .throw_hand_out   (throw_hand_out),
    .beat_index_out   (beat_index_out),
    .balls_live_out   (balls_live_out),
    .error_out        (error_out),
    .running_out      (running_out)
`ifdef SCHED_OCCUPANCY_EN
    ,
    .occupancy_out    (occupancy_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_pat(input logic [2:0] h0, input logic [2:0] h1, input logic [2:0] h2,
                         input logic [2:0] len, input logic [2:0] nb);
    for (int i = 0; i < MAX_LEN; i++) pattern_in[i] = 3'd0;
    pattern_in[0] = h0;
    pattern_in[1] = h1;
    pattern_in[2] = h2;
    pattern_length = len;
    num_balls_in = nb;
  endtask

  // Pulse new_beat for one cycle; returns at the falling edge after the update
  task automatic beat(input logic v);
    pattern_valid_in = v;
    @(negedge clk_in);
    new_beat = 1'b1;
    @(negedge clk_in);
    new_beat = 1'b0;
  endtask

  task automatic chk_throw(input string tag, input logic [2:0] ball, input logic [2:0] h,
                           input logic hand);
    chk({tag, "_valid"}, throw_valid_out, 1'b1);
    chk({tag, "_ball"}, throw_ball_out, ball);
    chk({tag, "_height"}, throw_height_out, h);
    chk({tag, "_hand"}, throw_hand_out, hand);
  endtask

  logic [2:0] exp_ball_3 [8] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0, 3'd1};
  logic [2:0] exp_ball_51 [7] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd0, 3'd0};

  initial begin
    set_pat(3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst_valid", throw_valid_out, 1'b0);
    chk("rst_running", running_out, 1'b0);
    chk("rst_error", error_out, 1'b0);
    chk("rst_live", balls_live_out, 3'd0);
    chk("rst_height", throw_height_out, 3'd0);
    chk("rst_index", beat_index_out, 3'd0);

    // "3", three balls, cascade
    set_pat(3'd3, 3'd0, 3'd0, 3'd1, 3'd3);
    for (int b = 0; b < 8; b++) begin
      beat(1'b1);
      chk_throw($sformatf("p3_b%0d", b), exp_ball_3[b], 3'd3, 1'(b % 2));
      chk($sformatf("p3_idx%0d", b), beat_index_out, 3'd0);
`ifdef SCHED_OCCUPANCY_EN
      if (b == 2) chk("p3_occupancy", occupancy_out, 7'b0000111);
`endif
    end
    @(negedge clk_in);
    chk("p3_pulse_width", throw_valid_out, 1'b0);
    chk("p3_live", balls_live_out, 3'd3);
    chk("p3_error", error_out, 1'b0);
    chk("p3_running", running_out, 1'b1);

    // synchronous reset between beats clears everything
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    chk("mrst_running", running_out, 1'b0);
    chk("mrst_live", balls_live_out, 3'd0);
    chk("mrst_ball", throw_ball_out, 3'd0);
    chk("mrst_height", throw_height_out, 3'd0);
    chk("mrst_hand", throw_hand_out, 1'b0);
    beat(1'b1);
    chk_throw("mrst_b0", 3'd0, 3'd3, 1'b0);
    beat(1'b1);
    chk_throw("mrst_b1", 3'd1, 3'd3, 1'b1);

    // switch to "441" on a beat: restart as beat 0
    set_pat(3'd4, 3'd4, 3'd1, 3'd3, 3'd3);
    beat(1'b1);
    chk_throw("rs_b0", 3'd0, 3'd4, 1'b0);
    chk("rs_idx0", beat_index_out, 3'd0);
    chk("rs_live0", balls_live_out, 3'd1);
    beat(1'b1);
    chk_throw("rs_b1", 3'd1, 3'd4, 1'b1);
    chk("rs_idx1", beat_index_out, 3'd1);
    beat(1'b1);
    chk_throw("rs_b2", 3'd2, 3'd1, 1'b0);
    chk("rs_idx2", beat_index_out, 3'd2);

    // valid drops while running
    beat(1'b0);
    chk("drop_valid", throw_valid_out, 1'b0);
    chk("drop_running", running_out, 1'b0);
    chk("drop_error", error_out, 1'b0);

    // "51"
    set_pat(3'd5, 3'd1, 3'd0, 3'd2, 3'd3);
    for (int b = 0; b < 7; b++) begin
      beat(1'b1);
      chk_throw($sformatf("p51_b%0d", b), exp_ball_51[b], (b % 2 == 0) ? 3'd5 : 3'd1, 1'(b % 2));
      chk($sformatf("p51_idx%0d", b), beat_index_out, 3'(b % 2));
    end
    beat(1'b0);
    chk("p51_stop", running_out, 1'b0);

    // "43" is not a valid siteswap: collision on beat 1
    set_pat(3'd4, 3'd3, 3'd0, 3'd2, 3'd3);
    beat(1'b1);
    chk_throw("p43_b0", 3'd0, 3'd4, 1'b0);
    beat(1'b1);
    chk("p43_coll_valid", throw_valid_out, 1'b0);
    chk("p43_coll_error", error_out, 1'b1);
    chk("p43_coll_running", running_out, 1'b0);
    beat(1'b1);
    chk("p43_frozen_valid", throw_valid_out, 1'b0);
    chk("p43_frozen_error", error_out, 1'b1);
    chk("p43_frozen_live", balls_live_out, 3'd1);
    chk("p43_frozen_idx", beat_index_out, 3'd0);
    beat(1'b0);
    chk("p43_idle_error", error_out, 1'b0);
    chk("p43_idle_running", running_out, 1'b0);

    // starvation: "3" claimed with only two balls
    set_pat(3'd3, 3'd0, 3'd0, 3'd1, 3'd2);
    beat(1'b1);
    chk_throw("starve_b0", 3'd0, 3'd3, 1'b0);
    beat(1'b1);
    chk_throw("starve_b1", 3'd1, 3'd3, 1'b1);
    beat(1'b1);
    chk("starve_valid", throw_valid_out, 1'b0);
    chk("starve_error", error_out, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/siteswap_scheduler.md
Name: siteswap_scheduler

Overview:
- Consumes the validated siteswap pattern, ball count and beat strobe from the pattern-entry stage.
- Runs a beat-by-beat juggling schedule. On each beat it decides which ball (if any) is thrown, its height and the throwing hand.
- Its throw events feed the display/animation stages downstream.
- Starts from an empty schedule and introduces balls one at a time, so any valid pattern can start, including excited-state patterns.

Parameters:
- MAX_LEN, 7, maximum pattern length (matches upstream array size)
- MAX_HEIGHT, 7, maximum throw height; also the number of landing slots

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- new_beat  input  1  one-cycle beat strobe
- pattern_in  input  3 x [6:0] unpacked  validated throw heights; element 0 is first
- pattern_length  input  3  number of active elements, 1..7
- num_balls_in  input  3  ball count of the pattern
- pattern_valid_in  input  1  pattern/length/num_balls are a valid siteswap
- throw_valid_out  output  1  one-cycle pulse: a throw occurred this beat
- throw_height_out  output  3  height of the throw
- throw_ball_out  output  3  id of the thrown ball, 0..6
- throw_hand_out  output  1  0 = left, 1 = right; alternates every beat
- beat_index_out  output  3  pattern index used for the last processed beat
- balls_live_out  output  3  balls introduced so far
- error_out  output  1  scheduler fault (collision / empty-hand / starvation)
- running_out  output  1  high in RUN

Behaviour:
- Clock and reset: one clock, clk_in; synchronous active-high reset rst_in.
- Reset: all outputs 0, all slots empty, state IDLE. Reset mid-operation aborts immediately and clears the schedule.
- Latency: every output updates on the cycle after new_beat. throw_valid_out is high for exactly one cycle.
- Schedule storage:
  - slot[0..MAX_HEIGHT-1], each {occ, id}.
  - Pre-beat, slot[i] holds the ball landing i beats from the current beat.
  - Processing a beat shifts the schedule: slot[i] <= slot[i+1], top slot empties.
  - The thrown ball is written to post-shift index h-1.
- States:
  - IDLE: on new_beat with pattern_valid_in=1, latch pattern/length/num_balls, clear slots, set idx=0, hand=0. Go to RUN and process this same beat as beat 0.
  - RUN, on new_beat:
    - If pattern_valid_in=0: go to IDLE, clear, no throw.
    - If pattern_valid_in=1 and any input differs from the latched copy: restart. Relatch, clear, and process as beat 0 of the new pattern.
    - Otherwise process the beat with h = pat[idx].
  - ERROR: error_out=1 and the schedule is frozen. A new_beat with pattern_valid_in=0 returns to IDLE and clears error_out; otherwise stay.
- Beat processing (RUN):
  - slot0 occupied and h>0: throw slot0.id.
  - slot0 occupied and h=0: go to ERROR (ball dropped).
  - slot0 empty and h>0 and balls_live<num_balls: throw new id = balls_live, then balls_live++.
  - slot0 empty and h>0 and balls_live=num_balls: go to ERROR (starvation).
  - slot0 empty and h=0: empty beat, throw_valid_out=0.
  - Collision: target post-shift slot h-1 already occupied goes to ERROR; the throw is not emitted.
  - Every processed beat, including empty ones: hand toggles; idx advances and wraps from pattern_length-1 to 0.
  - h > MAX_HEIGHT cannot occur (3-bit value).
- While running, new_beat with no state change leaves outputs other than throw_valid_out held.

Optional Feature:
- Macro: SCHED_OCCUPANCY_EN.
- Defined: adds output occupancy_out [MAX_HEIGHT-1:0], the post-beat slot occupancy vector, registered with the other outputs and reset to 0.
- Undefined: port absent, no logic.

Decomposition:
- Shared package juggle_pkg holds:
  - MAX_LEN and MAX_HEIGHT constants
  - sched_state_t enum {IDLE, RUN, ERROR}
  - slot_t packed struct {occ, id[2:0]}
- Sub-module landing_schedule: the slot shift register, with shift/place/clear controls and a combinational collision output for a given target index. The top level keeps the FSM, index, hand and ball counter.

Test Plan:
- "3", length 1, 3 balls, 8 beats → (ball, h, hand) = (0,3,0), (1,3,1), (2,3,0), (0,3,1), (1,3,0), (2,3,1), (0,3,0), (1,3,1); balls_live=3; error_out=0.
- "51", length 2, 3 balls, 7 beats → (0,5), (1,1), (1,5), (2,1), (2,5), (0,1), (0,5).
- "43", length 2, 3 balls, valid forced high → beat0 throws (0,4); beat1 collision at slot 2 → error_out=1, no throw pulse, later beats frozen. A beat with valid=0 → IDLE, error_out=0.
- Running "3", then the inputs change to "441" with valid=1 on a beat → restart that beat: ball 0 h4, idx 0, balls_live 1, hand 0.
- "3" running, rst_in asserted for 1 cycle between beats → all outputs 0, IDLE. The next valid beat yields ball 0 h3.
- Valid drops while running → no throw pulse, running_out=0. With SCHED_OCCUPANCY_EN defined, "3" after 3 beats → occupancy_out=3'b111 in low bits.
